// File: rtl/sevseg_scan_sched.sv
// Scan scheduler and two-requester display arbiter for the 16-bit seven-segment controller.
// Optional macro SEVSEG_IDLE_BLANK_EN adds a registered 'blank' output, high while no one owns the display.
module sevseg_scan_sched #(
    parameter int PRESCALE = 100000,
    parameter int MIN_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] val_a,
    input  logic        req_b,
    input  logic [15:0] val_b,
    output logic        grant_a,
    output logic        grant_b,
    output logic [1:0]  owner,
    output logic [15:0] disp_val,
`ifdef SEVSEG_IDLE_BLANK_EN
    output logic        blank,
`endif
    output logic [1:0]  digit_sel,
    output logic        frame_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = $clog2(MIN_HOLD + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);

    // Encodings double as the owner output code.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_OWN_A = 2'b01,
        S_OWN_B = 2'b10
    } state_t;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit_sel;
    state_t        r_state, w_state_nxt;
    logic [15:0]   r_disp, w_disp_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic          r_last_b, w_last_b_nxt;
    logic          r_grant_a, w_grant_a_nxt;
    logic          r_grant_b, w_grant_b_nxt;
    logic          r_frame_tick;
    logic          r_blank;
    logic          w_slot_end, w_fb, w_hold_full, w_take_a, w_take_b;

    assign w_slot_end  = (r_presc == PRESC_LAST);
    assign w_fb        = w_slot_end && (r_digit_sel == 2'd3);
    assign w_hold_full = (r_hold == HOLD_MAX);

    // NOTE: async reset in the sensitivity list makes reset take effect immediately, mid-frame included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_digit_sel <= 2'd0;
        end else if (w_slot_end) begin
            r_presc     <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
        end else begin
            r_presc     <= r_presc + 1'b1;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_disp_nxt    = r_disp;
        w_hold_nxt    = r_hold;
        w_last_b_nxt  = r_last_b;
        w_grant_a_nxt = 1'b0;
        w_grant_b_nxt = 1'b0;
        w_take_a      = 1'b0;
        w_take_b      = 1'b0;
        if (w_fb) begin
            case (r_state)
                S_IDLE: begin
                    if (req_a && (!req_b || r_last_b)) w_take_a = 1'b1;
                    else if (req_b)                    w_take_b = 1'b1;
                end
                S_OWN_A: begin
                    if (req_b && (!req_a || w_hold_full)) begin
                        w_take_b = 1'b1;
                    end else if (req_a) begin
                        w_disp_nxt = val_a;
                        if (!w_hold_full) w_hold_nxt = r_hold + 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_OWN_B: begin
                    if (req_a && (!req_b || w_hold_full)) begin
                        w_take_a = 1'b1;
                    end else if (req_b) begin
                        w_disp_nxt = val_b;
                        if (!w_hold_full) w_hold_nxt = r_hold + 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase

            if (w_take_a) begin
                w_state_nxt   = S_OWN_A;
                w_disp_nxt    = val_a;
                w_hold_nxt    = '0;
                w_last_b_nxt  = 1'b0;
                w_grant_a_nxt = 1'b1;
            end else if (w_take_b) begin
                w_state_nxt   = S_OWN_B;
                w_disp_nxt    = val_b;
                w_hold_nxt    = '0;
                w_last_b_nxt  = 1'b1;
                w_grant_b_nxt = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_disp       <= 16'h0000;
            r_hold       <= '0;
            r_last_b     <= 1'b1;
            r_grant_a    <= 1'b0;
            r_grant_b    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_blank      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_disp       <= w_disp_nxt;
            r_hold       <= w_hold_nxt;
            r_last_b     <= w_last_b_nxt;
            r_grant_a    <= w_grant_a_nxt;
            r_grant_b    <= w_grant_b_nxt;
            r_frame_tick <= w_fb;
            r_blank      <= (w_state_nxt == S_IDLE);
        end
    end

    assign grant_a    = r_grant_a;
    assign grant_b    = r_grant_b;
    assign owner      = r_state;
    assign disp_val   = r_disp;
    assign digit_sel  = r_digit_sel;
    assign frame_tick = r_frame_tick;
`ifdef SEVSEG_IDLE_BLANK_EN
    assign blank      = r_blank;
`else
    logic w_unused_blank;
    assign w_unused_blank = r_blank;
`endif

endmodule

// File: tb/tb_sevseg_scan_sched.sv
// Scoreboard bench for sevseg_scan_sched (PRESCALE=2, MIN_HOLD=2): expected frame outcomes are
// queued as requests are driven and popped when frame_tick marks the frame boundary update.
module tb_sevseg_scan_sched;

    localparam int PRESCALE = 2;
    localparam int MIN_HOLD = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] val_a = 16'h0000;
    logic [15:0] val_b = 16'h0000;
    logic        grant_a, grant_b, frame_tick;
    logic [1:0]  owner, digit_sel;
    logic [15:0] disp_val;
`ifdef SEVSEG_IDLE_BLANK_EN
    logic        blank;
`endif

    sevseg_scan_sched #(.PRESCALE(PRESCALE), .MIN_HOLD(MIN_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .val_a     (val_a),
        .req_b     (req_b),
        .val_b     (val_b),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .owner     (owner),
        .disp_val  (disp_val),
`ifdef SEVSEG_IDLE_BLANK_EN
        .blank     (blank),
`endif
        .digit_sel (digit_sel),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  owner;
        logic [15:0] disp;
        logic        ga;
        logic        gb;
    } fb_exp_t;

    fb_exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic expect_fb(input logic [1:0] o, input logic [15:0] d, input logic ga, input logic gb);
        fb_exp_t e;
        e.owner = o;
        e.disp  = d;
        e.ga    = ga;
        e.gb    = gb;
        exp_q.push_back(e);
    endtask

    task automatic wait_fb_and_check(input string tag);
        fb_exp_t e;
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_tick_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        check({tag, "_qsize"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "_owner"},   32'(owner),     32'(e.owner));
        check({tag, "_disp"},    32'(disp_val),  32'(e.disp));
        check({tag, "_grant_a"}, 32'(grant_a),   32'(e.ga));
        check({tag, "_grant_b"}, 32'(grant_b),   32'(e.gb));
        check({tag, "_digit0"},  32'(digit_sel), 32'd0);
`ifdef SEVSEG_IDLE_BLANK_EN
        check({tag, "_blank"},   32'(blank),     32'(e.owner == 2'b00));
`endif
        @(negedge clk);
        check({tag, "_tick_1cyc"}, 32'(frame_tick), 32'd0);
        check({tag, "_grant_1cyc"}, 32'({grant_a, grant_b}), 32'd0);
        check({tag, "_owner_kept"}, 32'(owner), 32'(e.owner));
    endtask

    // Releases reset on a falling edge, checks reset values and the first frame's digit scan.
    task automatic scan_from_reset(input string tag, input logic [1:0] o, input logic [15:0] d,
                                   input logic ga, input logic gb);
        expect_fb(o, d, ga, gb);
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_rst_owner"}, 32'(owner), 32'd0);
        check({tag, "_rst_disp"},  32'(disp_val), 32'd0);
        check({tag, "_rst_grant"}, 32'({grant_a, grant_b}), 32'd0);
`ifdef SEVSEG_IDLE_BLANK_EN
        check({tag, "_rst_blank"}, 32'(blank), 32'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, "_digit"}, 32'(digit_sel), 32'((i / 2) % 4));
            check({tag, "_tick_low"}, 32'(frame_tick), 32'd0);
        end
        wait_fb_and_check({tag, "_fb"});
    endtask

    initial begin
        scan_from_reset("idle", 2'b00, 16'h0000, 1'b0, 1'b0);

        req_a = 1'b1; val_a = 16'h1234;
        expect_fb(2'b01, 16'h1234, 1'b1, 1'b0);
        wait_fb_and_check("grant_a");

        val_a = 16'hBEEF;
        expect_fb(2'b01, 16'hBEEF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("disp_mid_frame", 32'(disp_val), 32'h1234);
        wait_fb_and_check("val_update");

        req_b = 1'b1; val_b = 16'h00FF;
        expect_fb(2'b01, 16'hBEEF, 1'b0, 1'b0);
        wait_fb_and_check("hold_a");
        expect_fb(2'b10, 16'h00FF, 1'b0, 1'b1);
        wait_fb_and_check("grant_b_after_hold");

        req_a = 1'b0; req_b = 1'b0;
        expect_fb(2'b00, 16'h00FF, 1'b0, 1'b0);
        wait_fb_and_check("idle_hold");

        req_a = 1'b1; val_a = 16'hA5A5;
        expect_fb(2'b01, 16'hA5A5, 1'b1, 1'b0);
        wait_fb_and_check("grant_a2");

        repeat (2) @(negedge clk);
        check("pre_rst_digit", 32'(digit_sel), 32'd1);
        #2 rst = 1'b1;
        req_a = 1'b0;
        #1;
        check("async_rst_owner", 32'(owner), 32'd0);
        check("async_rst_disp",  32'(disp_val), 32'd0);
        check("async_rst_digit", 32'(digit_sel), 32'd0);
        check("async_rst_tick",  32'(frame_tick), 32'd0);

        req_a = 1'b1; req_b = 1'b1; val_a = 16'h0A0A; val_b = 16'h0B0B;
        scan_from_reset("tie_a", 2'b01, 16'h0A0A, 1'b1, 1'b0);

        req_a = 1'b0; req_b = 1'b0;
        expect_fb(2'b00, 16'h0A0A, 1'b0, 1'b0);
        wait_fb_and_check("tie_idle");

        req_a = 1'b1; req_b = 1'b1;
        expect_fb(2'b10, 16'h0B0B, 1'b0, 1'b1);
        wait_fb_and_check("tie_alt_b");

        req_b = 1'b0; val_a = 16'h0C0C;
        expect_fb(2'b01, 16'h0C0C, 1'b1, 1'b0);
        wait_fb_and_check("b_release_to_a");

        req_a = 1'b0; req_b = 1'b1; val_b = 16'h0D0D;
        expect_fb(2'b10, 16'h0D0D, 1'b0, 1'b1);
        wait_fb_and_check("a_release_to_b");

        req_b = 1'b0;
        expect_fb(2'b00, 16'h0D0D, 1'b0, 1'b0);
        wait_fb_and_check("idle_again");

        expect_fb(2'b00, 16'h0D0D, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        req_b = 1'b1; val_b = 16'h7777;
        repeat (2) @(negedge clk);
        req_b = 1'b0;
        wait_fb_and_check("ignore_mid_frame");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
